kernel_build_sched: RTL and testbench
=====================================

# kernel_build_sched

Scheduler that shares the single Gaussian kernel generator between NUM_REQ blur-stage requesters in the ISP front end. It round-robin arbitrates configuration requests (sigma, kernel size), validates them, skips regeneration when the requested kernel is already held, and otherwise sequences the generator's start/done handshake with a watchdog. It holds the last good kernel for the convolution datapath and returns a per-request response.

## Interface
- MAX_KERNEL, 7, largest supported odd kernel dimension
- NUM_REQ, 2, number of requesters (≥2)
- TIMEOUT, 255, max WAIT cycles before the build is abandoned
- SW, $clog2(MAX_KERNEL), kernel-size field width (3 by default)
- clk  in  1  single clock, rising edge
- n_rst  in  1  asynchronous, active-low reset
- req  in  NUM_REQ  per-requester request level, held until that requester's grant
- req_sigma  in  NUM_REQ×3  sigma per requester
- req_size  in  NUM_REQ×SW  kernel size per requester
- cache_inv  in  1  invalidate the held kernel
- grant  out  NUM_REQ  one-hot, one-cycle pulse to the winning requester
- gen_start  out  1  one-cycle start pulse to the generator
- gen_sigma  out  3  sigma driven to the generator (latched)
- gen_kernel_size  out  SW  size driven to the generator (latched)
- gen_done  in  1  generator completion pulse
- gen_err  in  1  generator error, sampled with gen_done
- gen_kernel  in  MAX_KERNEL×MAX_KERNEL×8  generator kernel output
- kernel_out  out  MAX_KERNEL×MAX_KERNEL×8  held kernel
- kernel_valid  out  1  kernel_out is valid for held_sigma/held_size
- resp_valid  out  1  one-cycle response pulse
- resp_err  out  1  response carries an error (qualified by resp_valid)
- resp_id  out  $clog2(NUM_REQ)  index of the responded requester
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, CHECK, LAUNCH, WAIT, RESP.
- IDLE: if req≠0, the winner is the first set bit at or after rr_ptr (wrapping). At that edge: grant[winner]=1, cfg (sigma, size, id) latched into gen_sigma/gen_kernel_size/resp_id, go to CHECK.
- CHECK: invalid if sigma==0, size<3, size even, or size>MAX_KERNEL → RESP with err=1, no gen_start. Hit if kernel_valid and cfg==held cfg → RESP with err=0, no gen_start. Otherwise → LAUNCH.
- LAUNCH: gen_start=1 for exactly one cycle; timer cleared; → WAIT.
- WAIT: timer increments each cycle. On gen_done: kernel_out←gen_kernel, held cfg←cfg, kernel_valid←~gen_err, resp_err←gen_err, → RESP. If timer reaches TIMEOUT without gen_done: kernel_valid←0, resp_err←1, → RESP. gen_done outside WAIT is ignored.
- RESP: resp_valid=1 for one cycle; rr_ptr←(winner+1) mod NUM_REQ; → IDLE.
- cache_inv clears kernel_valid on the next edge in any state. If asserted in WAIT together with or before gen_done, the kernel still loads into kernel_out but kernel_valid ends 0 (cache_inv wins). In CHECK it forces a miss.
- A requester still holding req after its response is treated as a new request; round-robin guarantees another pending requester wins first.
- Reset (any time, including mid-WAIT): state IDLE, rr_ptr=0, timer=0, all outputs 0 (grant, gen_start, gen_sigma, gen_kernel_size, kernel_out, kernel_valid, resp_valid, resp_err, resp_id, busy). A gen_done arriving after reset is ignored.

## Timing
- req seen high at edge k → grant pulse and busy high after edge k (CHECK).
- Hit/invalid: resp_valid during the cycle after edge k+1; back in IDLE after edge k+2.
- Miss: gen_start high the cycle after edge k+1; WAIT from edge k+2. gen_done sampled at edge m → resp_valid high the cycle after edge m, kernel_out/kernel_valid updated at the same edge.
- Timeout: WAIT lasts exactly TIMEOUT cycles, then RESP.
- Back-to-back throughput: one request per 3 cycles (hit), per 4+gen-latency (miss).
- Outputs registered; no combinational path from req to grant.

## Test plan
- Reset, req[0] with sigma=2,size=3; generator returns done after 20 cycles → one gen_start, resp_valid with id=0, err=0, kernel_valid=1, kernel_out equals gen_kernel.
- Repeat req[0] sigma=2,size=3 → hit: no gen_start, resp_valid 2 cycles after grant, err=0.
- req[0] and req[1] high simultaneously from reset → grant order 1-hot 0 then 1, then 0 again on next pair (round-robin), each with its own resp_id.
- Invalid configs (sigma=0; size=4; size=1; size=9 with SW wide enough) → resp_err=1, no gen_start, kernel_valid unchanged.
- Generator never asserts done → resp_err=1 exactly TIMEOUT cycles after WAIT entry, kernel_valid=0; gen_err=1 with done → resp_err=1, kernel_valid=0.
- cache_inv during WAIT, and n_rst asserted mid-WAIT → kernel_valid=0; after reset all outputs 0 and a late gen_done causes no response.

Source files
------------

// File: rtl/kernel_build_sched_if.sv
// Signal bundle between the kernel build scheduler, its blur-stage requesters and the
// shared Gaussian kernel generator. The master modport is the scheduler's view.
interface kernel_build_sched_if #(
    parameter int unsigned MAX_KERNEL = 7,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned SW         = $clog2(MAX_KERNEL),
    parameter int unsigned IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
);
    localparam int unsigned KW = MAX_KERNEL * MAX_KERNEL * 8;

    // Requester side
    logic [NUM_REQ-1:0]    req;
    logic [NUM_REQ*3-1:0]  req_sigma;
    logic [NUM_REQ*SW-1:0] req_size;
    logic                  cache_inv;
    logic [NUM_REQ-1:0]    grant;

    // Generator side
    logic                  gen_start;
    logic [2:0]            gen_sigma;
    logic [SW-1:0]         gen_kernel_size;
    logic                  gen_done;
    logic                  gen_err;
    logic [KW-1:0]         gen_kernel;

    // Held kernel and response
    logic [KW-1:0]         kernel_out;
    logic                  kernel_valid;
    logic                  resp_valid;
    logic                  resp_err;
    logic [IDW-1:0]        resp_id;
    logic                  busy;

    modport master (
        input  req, req_sigma, req_size, cache_inv, gen_done, gen_err, gen_kernel,
        output grant, gen_start, gen_sigma, gen_kernel_size, kernel_out, kernel_valid,
        output resp_valid, resp_err, resp_id, busy
    );

    modport slave (
        output req, req_sigma, req_size, cache_inv, gen_done, gen_err, gen_kernel,
        input  grant, gen_start, gen_sigma, gen_kernel_size, kernel_out, kernel_valid,
        input  resp_valid, resp_err, resp_id, busy
    );
endinterface

// File: rtl/kernel_build_sched.sv
// Round-robin scheduler sharing one Gaussian kernel generator between NUM_REQ blur stages;
// validates configs, reuses the held kernel on a hit and watchdogs each generator build.
module kernel_build_sched #(
    parameter int unsigned MAX_KERNEL = 7,
    parameter int unsigned NUM_REQ    = 2,
    parameter int unsigned TIMEOUT    = 255,
    parameter int unsigned SW         = $clog2(MAX_KERNEL)
) (
    input  logic                  clk,
    input  logic                  n_rst,
    kernel_build_sched_if.master  bus
);
    localparam int unsigned IDW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned KW  = MAX_KERNEL * MAX_KERNEL * 8;
    localparam int unsigned TW  = $clog2(TIMEOUT + 1);

    typedef enum logic [2:0] {
        StIdle,
        StCheck,
        StLaunch,
        StWait,
        StResp
    } state_e;

    state_e          state_q;
    logic [IDW-1:0]  rr_ptr_q;
    logic [TW-1:0]   timer_q;
    logic [2:0]      held_sigma_q;
    logic [SW-1:0]   held_size_q;
    logic            inv_pend_q;

    logic [NUM_REQ-1:0] grant_q;
    logic               gen_start_q;
    logic [2:0]         gen_sigma_q;
    logic [SW-1:0]      gen_kernel_size_q;
    logic [KW-1:0]      kernel_out_q;
    logic               kernel_valid_q;
    logic               resp_valid_q;
    logic               resp_err_q;
    logic [IDW-1:0]     resp_id_q;
    logic               busy_q;

    // Round-robin pick: first pending requester at or after rr_ptr_q, wrapping.
    logic           win_found;
    logic [IDW-1:0] win_idx;
    logic [IDW-1:0] cand;
    logic [2:0]     win_sigma;
    logic [SW-1:0]  win_size;

    always_comb begin
        win_found = 1'b0;
        win_idx   = '0;
        cand      = '0;
        win_sigma = '0;
        win_size  = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            cand = IDW'((32'(rr_ptr_q) + i) % NUM_REQ);
            if (!win_found && bus.req[cand]) begin
                win_found = 1'b1;
                win_idx   = cand;
                win_sigma = bus.req_sigma[cand*3 +: 3];
                win_size  = bus.req_size[cand*SW +: SW];
            end
        end
    end

    // Config checks run on the latched generator config while in CHECK.
    logic cfg_bad;
    logic cfg_hit;

    assign cfg_bad = (gen_sigma_q == 3'd0)
                  || (int'(gen_kernel_size_q) < 3)
                  || !gen_kernel_size_q[0]
                  || (int'(gen_kernel_size_q) > int'(MAX_KERNEL));

    assign cfg_hit = kernel_valid_q && !bus.cache_inv
                  && (gen_sigma_q == held_sigma_q)
                  && (gen_kernel_size_q == held_size_q);

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state_q           <= StIdle;
            rr_ptr_q          <= '0;
            timer_q           <= '0;
            held_sigma_q      <= '0;
            held_size_q       <= '0;
            inv_pend_q        <= 1'b0;
            grant_q           <= '0;
            gen_start_q       <= 1'b0;
            gen_sigma_q       <= '0;
            gen_kernel_size_q <= '0;
            kernel_out_q      <= '0;
            kernel_valid_q    <= 1'b0;
            resp_valid_q      <= 1'b0;
            resp_err_q        <= 1'b0;
            resp_id_q         <= '0;
            busy_q            <= 1'b0;
        end else begin
            grant_q      <= '0;
            gen_start_q  <= 1'b0;
            resp_valid_q <= 1'b0;
            if (bus.cache_inv) begin
                kernel_valid_q <= 1'b0;
            end

            unique case (state_q)
                StIdle: begin
                    if (win_found) begin
                        grant_q           <= NUM_REQ'(1) << win_idx;
                        gen_sigma_q       <= win_sigma;
                        gen_kernel_size_q <= win_size;
                        resp_id_q         <= win_idx;
                        busy_q            <= 1'b1;
                        state_q           <= StCheck;
                    end
                end

                StCheck: begin
                    inv_pend_q <= 1'b0;
                    if (cfg_bad) begin
                        resp_err_q   <= 1'b1;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end else if (cfg_hit) begin
                        resp_err_q   <= 1'b0;
                        resp_valid_q <= 1'b1;
                        state_q      <= StResp;
                    end else begin
                        gen_start_q <= 1'b1;
                        state_q     <= StLaunch;
                    end
                end

                StLaunch: begin
                    timer_q <= '0;
                    if (bus.cache_inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    state_q <= StWait;
                end

                StWait: begin
                    if (bus.cache_inv) begin
                        inv_pend_q <= 1'b1;
                    end
                    if (bus.gen_done) begin
                        // An invalidate seen during the build leaves the new kernel unusable.
                        kernel_out_q   <= bus.gen_kernel;
                        held_sigma_q   <= gen_sigma_q;
                        held_size_q    <= gen_kernel_size_q;
                        kernel_valid_q <= !bus.gen_err && !bus.cache_inv && !inv_pend_q;
                        resp_err_q     <= bus.gen_err;
                        resp_valid_q   <= 1'b1;
                        state_q        <= StResp;
                    end else if (timer_q == TW'(TIMEOUT - 1)) begin
                        kernel_valid_q <= 1'b0;
                        resp_err_q     <= 1'b1;
                        resp_valid_q   <= 1'b1;
                        state_q        <= StResp;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end

                StResp: begin
                    rr_ptr_q <= (resp_id_q == IDW'(NUM_REQ - 1)) ? '0 : resp_id_q + 1'b1;
                    busy_q   <= 1'b0;
                    state_q  <= StIdle;
                end

                default: begin
                    busy_q  <= 1'b0;
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.grant           = grant_q;
    assign bus.gen_start       = gen_start_q;
    assign bus.gen_sigma       = gen_sigma_q;
    assign bus.gen_kernel_size = gen_kernel_size_q;
    assign bus.kernel_out      = kernel_out_q;
    assign bus.kernel_valid    = kernel_valid_q;
    assign bus.resp_valid      = resp_valid_q;
    assign bus.resp_err        = resp_err_q;
    assign bus.resp_id         = resp_id_q;
    assign bus.busy            = busy_q;
endmodule

// File: tb/tb_kernel_build_sched.sv
// Scoreboard bench for kernel_build_sched: per-feature tasks drive requests and a generator
// model, queue expected responses and compare them as the scheduler answers.
module tb_kernel_build_sched;
    localparam int unsigned MK  = 7;
    localparam int unsigned NR  = 2;
    localparam int unsigned TO  = 255;
    localparam int unsigned SW  = $clog2(MK);
    localparam int unsigned IDW = (NR > 1) ? $clog2(NR) : 1;
    localparam int unsigned KW  = MK * MK * 8;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic           err;
    } resp_t;

    logic clk;
    logic n_rst;

    kernel_build_sched_if #(.MAX_KERNEL(MK), .NUM_REQ(NR), .SW(SW)) bus ();

    kernel_build_sched #(
        .MAX_KERNEL(MK),
        .NUM_REQ   (NR),
        .TIMEOUT   (TO),
        .SW        (SW)
    ) dut (
        .clk  (clk),
        .n_rst(n_rst),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_fail   = 0;
    int start_cnt = 0;

    resp_t         exp_q[$];
    logic          model_valid;
    logic [KW-1:0] model_kernel;

    always @(negedge clk) begin
        if (bus.gen_start === 1'b1) start_cnt <= start_cnt + 1;
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        bus.req        = '0;
        bus.req_sigma  = '0;
        bus.req_size   = '0;
        bus.cache_inv  = 1'b0;
        bus.gen_done   = 1'b0;
        bus.gen_err    = 1'b0;
        bus.gen_kernel = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        n_rst = 1'b0;
        tick();
        tick();
        n_rst = 1'b1;
        model_valid  = 1'b0;
        model_kernel = '0;
    endtask

    task automatic test_reset();
        clear_inputs();
        n_rst = 1'b0;
        bus.req = '1;
        tick();
        tick();
        n_checks++;
        if ({bus.grant, bus.gen_start, bus.gen_sigma, bus.gen_kernel_size, bus.kernel_valid,
             bus.resp_valid, bus.resp_err, bus.resp_id, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_ctrl: got grant=%b start=%b sigma=%0d size=%0d kv=%b rv=%b re=%b id=%0d busy=%b, expected all 0",
                     bus.grant, bus.gen_start, bus.gen_sigma, bus.gen_kernel_size,
                     bus.kernel_valid, bus.resp_valid, bus.resp_err, bus.resp_id, bus.busy);
        end
        n_checks++;
        if (bus.kernel_out !== '0) begin
            n_fail++;
            $display("FAIL reset_kernel: got %h expected 0", bus.kernel_out);
        end
        bus.req = '0;
        n_rst = 1'b1;
        model_valid  = 1'b0;
        model_kernel = '0;
        tick();
    endtask

    // One request from requester id; lat < 0 means the generator never answers.
    task automatic run_req(input int id, input logic [2:0] sigma, input logic [SW-1:0] size,
                           input int lat, input logic gerr, input int inv_at,
                           input logic exp_err, input logic exp_launch, input logic exp_valid,
                           input string name);
        int            c;
        int            resp_c;
        int            exp_c;
        int            starts0;
        logic          got;
        resp_t         r;
        logic [KW-1:0] pat;
        for (int i = 0; i < int'(KW / 8); i++) pat[i*8 +: 8] = 8'($urandom);
        exp_q.push_back({IDW'(id), exp_err});
        bus.req_sigma[id*3 +: 3]   = sigma;
        bus.req_size[id*SW +: SW]  = size;
        bus.req[id]                = 1'b1;
        starts0 = start_cnt;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            tick();
            got = (bus.grant != '0);
        end
        n_checks++;
        if (bus.grant !== NR'(1 << id)) begin
            n_fail++;
            $display("FAIL %s grant: got %b expected %b", name, bus.grant, NR'(1 << id));
        end
        bus.req[id] = 1'b0;
        n_checks++;
        if (bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL %s busy_after_grant: got %b expected 1", name, bus.busy);
        end

        if (!exp_launch) exp_c = 1;
        else if (lat < 0) exp_c = 2 + TO;
        else exp_c = 2 + lat;

        resp_c = -1;
        c = 0;
        while (resp_c < 0 && c < int'(TO) + 40) begin
            bus.gen_done   = exp_launch && (lat >= 0) && (c == lat + 1);
            bus.gen_err    = bus.gen_done & gerr;
            bus.gen_kernel = pat;
            bus.cache_inv  = (c == inv_at);
            tick();
            c++;
            if (bus.resp_valid === 1'b1) resp_c = c;
        end
        bus.gen_done  = 1'b0;
        bus.gen_err   = 1'b0;
        bus.cache_inv = 1'b0;

        n_checks++;
        if (resp_c != exp_c) begin
            n_fail++;
            $display("FAIL %s resp_cycle: got %0d expected %0d", name, resp_c, exp_c);
        end
        r = exp_q.pop_front();
        n_checks++;
        if (bus.resp_id !== r.id || bus.resp_err !== r.err) begin
            n_fail++;
            $display("FAIL %s resp: got id=%0d err=%b expected id=%0d err=%b",
                     name, bus.resp_id, bus.resp_err, r.id, r.err);
        end
        if (exp_launch && lat >= 0) model_kernel = pat;
        model_valid = exp_valid;
        n_checks++;
        if (bus.kernel_valid !== model_valid) begin
            n_fail++;
            $display("FAIL %s kernel_valid: got %b expected %b", name, bus.kernel_valid,
                     model_valid);
        end
        n_checks++;
        if (bus.kernel_out !== model_kernel) begin
            n_fail++;
            $display("FAIL %s kernel_out: got %h expected %h", name, bus.kernel_out[63:0],
                     model_kernel[63:0]);
        end
        tick();
        n_checks++;
        if (bus.busy !== 1'b0 || (start_cnt - starts0) != (exp_launch ? 1 : 0)) begin
            n_fail++;
            $display("FAIL %s idle: got busy=%b starts=%0d expected busy=0 starts=%0d",
                     name, bus.busy, start_cnt - starts0, exp_launch ? 1 : 0);
        end
    endtask

    task automatic test_miss();
        run_req(0, 3'd2, SW'(3), 20, 1'b0, -1, 1'b0, 1'b1, 1'b1, "miss");
    endtask

    task automatic test_hit();
        run_req(0, 3'd2, SW'(3), 0, 1'b0, -1, 1'b0, 1'b0, 1'b1, "hit0");
        run_req(1, 3'd2, SW'(3), 0, 1'b0, -1, 1'b0, 1'b0, 1'b1, "hit1");
    endtask

    task automatic test_invalid();
        run_req(0, 3'd0, SW'(3), 0, 1'b0, -1, 1'b1, 1'b0, 1'b1, "sigma0");
        run_req(0, 3'd2, SW'(4), 0, 1'b0, -1, 1'b1, 1'b0, 1'b1, "size4");
        run_req(1, 3'd2, SW'(1), 0, 1'b0, -1, 1'b1, 1'b0, 1'b1, "size1");
        run_req(1, 3'd5, SW'(0), 0, 1'b0, -1, 1'b1, 1'b0, 1'b1, "size0");
    endtask

    task automatic test_gen_fail();
        run_req(0, 3'd3, SW'(5), -1, 1'b0, -1, 1'b1, 1'b1, 1'b0, "timeout");
        run_req(0, 3'd3, SW'(5), 6, 1'b0, -1, 1'b0, 1'b1, 1'b1, "rebuild");
        run_req(0, 3'd4, SW'(5), 8, 1'b1, -1, 1'b1, 1'b1, 1'b0, "gen_err");
    endtask

    task automatic test_cache_inv();
        run_req(1, 3'd4, SW'(7), 3, 1'b0, -1, 1'b0, 1'b1, 1'b1, "inv_build");
        run_req(1, 3'd4, SW'(7), 3, 1'b0, 0, 1'b0, 1'b1, 1'b1, "inv_check");
        bus.cache_inv = 1'b1;
        tick();
        bus.cache_inv = 1'b0;
        n_checks++;
        if (bus.kernel_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL inv_idle kernel_valid: got %b expected 0", bus.kernel_valid);
        end
        model_valid = 1'b0;
        run_req(1, 3'd6, SW'(3), 10, 1'b0, 5, 1'b0, 1'b1, 1'b0, "inv_wait");
        run_req(1, 3'd6, SW'(3), 4, 1'b0, -1, 1'b0, 1'b1, 1'b1, "inv_rebuild");
        run_req(1, 3'd2, SW'(5), 4, 1'b0, 5, 1'b0, 1'b1, 1'b0, "inv_with_done");
    endtask

    task automatic test_round_robin();
        int    order [5];
        int    t;
        logic  got;
        resp_t r;
        order = '{0, 1, 0, 1, 0};
        do_reset();
        bus.req_sigma[0 +: 3]   = 3'd0;
        bus.req_size[0 +: SW]   = SW'(3);
        bus.req_sigma[3 +: 3]   = 3'd3;
        bus.req_size[SW +: SW]  = SW'(4);
        exp_q.push_back({IDW'(0), 1'b1});
        exp_q.push_back({IDW'(1), 1'b1});
        bus.req = 2'b11;
        for (int g = 0; g < 5; g++) begin
            got = 1'b0;
            for (t = 0; t < 10 && !got; t++) begin
                tick();
                got = (bus.grant != '0);
            end
            n_checks++;
            if (bus.grant !== NR'(1 << order[g])) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b expected %b", g, bus.grant,
                         NR'(1 << order[g]));
            end
            // Requester 0 keeps its request after the first grant.
            if (g == 0) exp_q.push_back({IDW'(0), 1'b1});
            else bus.req[order[g]] = 1'b0;
            got = 1'b0;
            for (t = 0; t < 10 && !got; t++) begin
                tick();
                got = (bus.resp_valid === 1'b1);
            end
            r = exp_q.pop_front();
            n_checks++;
            if (!got || bus.resp_id !== r.id || bus.resp_err !== r.err) begin
                n_fail++;
                $display("FAIL rr_resp%0d: got seen=%b id=%0d err=%b expected id=%0d err=%b",
                         g, got, bus.resp_id, bus.resp_err, r.id, r.err);
            end
            if (g == 2) begin
                exp_q.push_back({IDW'(1), 1'b1});
                exp_q.push_back({IDW'(0), 1'b1});
                bus.req = 2'b11;
            end
        end
        bus.req = '0;
        tick();
    endtask

    task automatic test_back_to_back();
        int    cyc;
        int    ng;
        int    nr;
        int    gcyc [3];
        int    starts0;
        resp_t r;
        run_req(0, 3'd1, SW'(7), 2, 1'b0, -1, 1'b0, 1'b1, 1'b1, "b2b_build");
        starts0 = start_cnt;
        for (int i = 0; i < 3; i++) exp_q.push_back({IDW'(0), 1'b0});
        bus.req_sigma[0 +: 3] = 3'd1;
        bus.req_size[0 +: SW] = SW'(7);
        bus.req[0] = 1'b1;
        cyc = 0;
        ng  = 0;
        nr  = 0;
        while (nr < 3 && cyc < 40) begin
            tick();
            cyc++;
            if (bus.grant != '0 && ng < 3) begin
                gcyc[ng] = cyc;
                ng++;
                if (ng == 3) bus.req[0] = 1'b0;
            end
            if (bus.resp_valid === 1'b1) begin
                r = exp_q.pop_front();
                nr++;
                n_checks++;
                if (bus.resp_id !== r.id || bus.resp_err !== r.err) begin
                    n_fail++;
                    $display("FAIL b2b_resp%0d: got id=%0d err=%b expected id=%0d err=%b",
                             nr, bus.resp_id, bus.resp_err, r.id, r.err);
                end
            end
        end
        bus.req[0] = 1'b0;
        tick();
        n_checks++;
        if (ng != 3 || gcyc[1] - gcyc[0] != 3 || gcyc[2] - gcyc[1] != 3) begin
            n_fail++;
            $display("FAIL b2b_spacing: got %0d grants at %0d,%0d,%0d expected 3 grants 3 apart",
                     ng, gcyc[0], gcyc[1], gcyc[2]);
        end
        n_checks++;
        if (start_cnt != starts0) begin
            n_fail++;
            $display("FAIL b2b_starts: got %0d expected 0", start_cnt - starts0);
        end
    endtask

    task automatic test_reset_mid_wait();
        logic got;
        logic seen;
        bus.req_sigma[0 +: 3] = 3'd5;
        bus.req_size[0 +: SW] = SW'(3);
        bus.req[0] = 1'b1;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            tick();
            got = (bus.grant != '0);
        end
        bus.req[0] = 1'b0;
        got = 1'b0;
        for (int t = 0; t < 8 && !got; t++) begin
            tick();
            got = (bus.gen_start === 1'b1);
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL rst_wait_start: got no gen_start expected one");
        end
        for (int t = 0; t < 5; t++) tick();
        #2 n_rst = 1'b0;
        #1;
        n_checks++;
        if ({bus.grant, bus.gen_start, bus.gen_sigma, bus.gen_kernel_size, bus.kernel_valid,
             bus.resp_valid, bus.resp_err, bus.resp_id, bus.busy} !== '0
            || bus.kernel_out !== '0) begin
            n_fail++;
            $display("FAIL rst_wait_outputs: got kv=%b busy=%b sigma=%0d size=%0d expected all 0",
                     bus.kernel_valid, bus.busy, bus.gen_sigma, bus.gen_kernel_size);
        end
        tick();
        n_rst = 1'b1;
        model_valid  = 1'b0;
        model_kernel = '0;
        bus.gen_kernel = '1;
        bus.gen_done   = 1'b1;
        tick();
        bus.gen_done = 1'b0;
        seen = 1'b0;
        for (int t = 0; t < 20; t++) begin
            tick();
            if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0 || bus.kernel_valid !== 1'b0)
                seen = 1'b1;
        end
        n_checks++;
        if (seen !== 1'b0 || bus.kernel_out !== '0) begin
            n_fail++;
            $display("FAIL late_done: got activity=%b expected no response or kernel load",
                     seen);
        end
    endtask

    initial begin
        clear_inputs();
        n_rst = 1'b0;
        model_valid  = 1'b0;
        model_kernel = '0;
        test_reset();
        test_miss();
        test_hit();
        test_invalid();
        test_gen_fail();
        test_cache_inv();
        test_round_robin();
        test_back_to_back();
        test_reset_mid_wait();
        n_checks++;
        if (exp_q.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
